mips_step_ctrl: RTL and testbench
=================================

// Module: mips_step_ctrl
// PURPOSE
//  Hardware stepping/trace controller for Soc_Mips on the FPGA: drives the SoC's reset and a clock
//  enable instead of a bench hand-toggling them. Supports single-step or free-run execution and
//  captures PC/instruction/ALU/flags after every step into a valid/ready trace port for display/UART.
//  Sits between board buttons (debounced) and the Soc_Mips clk/rst/debug outputs.
// PARAMETERS
//  RST_CYCLES  4   cycles cpu_rst held high after any reset event (>=1)
//  CNT_W       16  width of executed-step counter
//  PC_W        6   width of pc_in / trace_pc
//  DATA_W      8   width of alu_in / trace_alu
// PORTS
//  clk          in   1       system clock, shared with Soc_Mips
//  rst          in   1       synchronous, active-low reset
//  step_req     in   1       one-cycle pulse: execute one instruction
//  run_req      in   1       level: free-run while high
//  cpu_rst_req  in   1       one-cycle pulse: re-reset the SoC
//  pc_in        in   PC_W    SoC PCout
//  instr_in     in   32      SoC Instruction
//  alu_in       in   DATA_W  SoC ALUResult
//  regwr_in     in   1       SoC RegWrite
//  memwr_in     in   1       SoC MemWrite
//  trace_ready  in   1       consumer accepts trace record
//  cpu_rst      out  1       active-high reset to SoC
//  cpu_ce       out  1       clock enable to SoC (one pulse = one instruction)
//  trace_valid  out  1       trace record available
//  trace_pc     out  PC_W    captured PC
//  trace_instr  out  32      captured instruction
//  trace_alu    out  DATA_W  captured ALU result
//  trace_flags  out  2       {regwr, memwr} captured
//  cycle_cnt    out  CNT_W   instructions executed since last reset, saturating
// BEHAVIOUR
//  - rst low at clk edge: state RST_HOLD, hold counter=RST_CYCLES; cpu_rst=1, cpu_ce=0, trace_valid=0,
//    trace_* =0, cycle_cnt=0, bp_hit=0. All outputs registered.
//  - States: RST_HOLD, IDLE, STEP, CAPTURE, WAIT.
//  - RST_HOLD: cpu_rst=1 for exactly RST_CYCLES cycles after rst high, then IDLE (cpu_rst=0).
//  - IDLE: step_req or run_req -> STEP. Both together = one step, identical to step_req alone.
//  - STEP: cpu_ce=1 for exactly this cycle; cycle_cnt+1 (holds at 2^CNT_W-1); -> CAPTURE.
//  - CAPTURE: SoC outputs reflect post-step state; latch pc/instr/alu/flags at end of cycle; -> WAIT.
//  - WAIT: trace_valid=1, payload stable. valid&&ready -> STEP if run_req high, else IDLE;
//    trace_valid=0 the following cycle. No ready -> stay; SoC stalled (cpu_ce=0).
//  - Throughput with trace_ready=1 and run_req=1: one cpu_ce pulse every 3 cycles.
//  - step_req outside IDLE is dropped, never queued.
//  - cpu_rst_req in any state (incl. RST_HOLD): -> RST_HOLD, hold counter reloaded, cycle_cnt=0,
//    trace_valid=0 next cycle (pending record discarded). Wins over simultaneous step/run/ready.
// CONFIGURATION
//  MIPS_STEP_BP_EN defined: extra ports bp_addr in PC_W, bp_en in 1, bp_hit out 1.
//   In WAIT with bp_en=1 and trace_pc==bp_addr: on handshake go IDLE regardless of run_req;
//   bp_hit=1 (sticky) and run_req ignored until it has been sampled low. bp_hit clears on
//   step_req accepted in IDLE, cpu_rst_req, or rst. Single steps are never blocked.
//  Not defined: ports absent, run mode only stops on run_req low or reset.
// TESTING
//  1. rst low 2 cycles then high, RST_CYCLES=4 -> cpu_rst high exactly 4 cycles after release,
//     cpu_ce=0, trace_valid=0, cycle_cnt=0 throughout.
//  2. IDLE, step_req pulse, trace_ready=1, pc_in=6'd4 after ce -> one cpu_ce cycle, trace_valid
//     one cycle 2 cycles later, trace_pc=4, cycle_cnt=1.
//  3. trace_ready=0 for 10 cycles while trace_valid, step_req/run_req toggling -> payload stable,
//     zero cpu_ce pulses; ready=1 -> record accepted, valid low next cycle.
//  4. run_req high 30 cycles, trace_ready=1 -> cpu_ce every 3rd cycle, cycle_cnt=10; CNT_W=4 with
//     20 steps -> cycle_cnt stays 15.
//  5. cpu_rst_req with step_req in same cycle during WAIT -> trace_valid low next cycle, cpu_rst high
//     4 cycles, cycle_cnt=0, no cpu_ce.
//  6. MIPS_STEP_BP_EN, bp_addr=6'd12, bp_en=1, run with PC 4,8,12,16 -> halts after pc=12 accepted,
//     bp_hit=1, no cpu_ce while run_req stays high; run_req low then high -> resumes, pc=16.

Source files
------------

// File: rtl/mips_step_ctrl_if.sv
// mips_step_ctrl_if: valid/ready trace record bus from the stepping controller to a consumer
// (display or UART formatter). The controller holds one captured record per executed step.
//   valid  master->slave  record available, payload stable while valid
//   ready  slave->master  consumer accepts the record this cycle
//   pc     master->slave  captured PC (PC_W bits)
//   instr  master->slave  captured 32-bit instruction
//   alu    master->slave  captured ALU result (DATA_W bits)
//   flags  master->slave  captured {regwr, memwr}
interface mips_step_ctrl_if #(
   parameter int unsigned PC_W   = 6,
   parameter int unsigned DATA_W = 8
);
   logic              valid;
   logic              ready;
   logic [PC_W-1:0]   pc;
   logic [31:0]       instr;
   logic [DATA_W-1:0] alu;
   logic [1:0]        flags;

   modport master (output valid, pc, instr, alu, flags, input ready);
   modport slave  (input valid, pc, instr, alu, flags, output ready);
endinterface

// File: rtl/mips_step_ctrl.sv
// mips_step_ctrl: stepping/trace controller for Soc_Mips. Drives the SoC reset and clock enable,
// executes single steps or free-runs, and captures PC/instruction/ALU/flags after every step
// into a valid/ready trace record.
// Ports:
//   clk, rst            system clock; synchronous active-low reset
//   step_req            one-cycle pulse, execute one instruction (only honoured in idle)
//   run_req             level, free-run while high
//   cpu_rst_req         one-cycle pulse, re-reset the SoC (highest priority, any state)
//   pc_in .. memwr_in   SoC debug outputs sampled one cycle after the enable pulse
//   cpu_rst, cpu_ce     active-high SoC reset and one-instruction clock enable
//   cycle_cnt           saturating count of instructions executed since the last reset
//   trace               trace record bus (master side)
// Optional breakpoint (define MIPS_STEP_BP_EN): bp_addr, bp_en in; bp_hit out (sticky).
// All outputs are registered.
module mips_step_ctrl #(
   parameter int unsigned RST_CYCLES = 4,
   parameter int unsigned CNT_W      = 16,
   parameter int unsigned PC_W       = 6,
   parameter int unsigned DATA_W     = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              step_req,
   input  logic              run_req,
   input  logic              cpu_rst_req,
   input  logic [PC_W-1:0]   pc_in,
   input  logic [31:0]       instr_in,
   input  logic [DATA_W-1:0] alu_in,
   input  logic              regwr_in,
   input  logic              memwr_in,
`ifdef MIPS_STEP_BP_EN
   input  logic [PC_W-1:0]   bp_addr,
   input  logic              bp_en,
   output logic              bp_hit,
`endif
   output logic              cpu_rst,
   output logic              cpu_ce,
   output logic [CNT_W-1:0]  cycle_cnt,
   mips_step_ctrl_if.master  trace
);

   localparam int unsigned HOLD_W = $clog2(RST_CYCLES + 1);

   typedef enum logic [2:0] {StRstHold, StIdle, StStep, StCapture, StWait} state_e;

   state_e              state_q, state_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                cpu_rst_q, cpu_ce_q;
   logic                valid_q, valid_d;
   logic [PC_W-1:0]     pc_q, pc_d;
   logic [31:0]         instr_q, instr_d;
   logic [DATA_W-1:0]   alu_q, alu_d;
   logic [1:0]          flags_q, flags_d;
   logic                bp_hit_q, bp_hit_d;
   // Run mode stays blocked after a breakpoint until run_req has been seen low.
   logic                run_blk_q, run_blk_d;
   logic                run_ok;
   logic                bp_match;

`ifdef MIPS_STEP_BP_EN
   assign bp_match = bp_en && (pc_q == bp_addr);
   assign bp_hit   = bp_hit_q;
`else
   assign bp_match = 1'b0;
`endif

   assign run_ok = run_req && !run_blk_q;

   always_comb begin
      state_d   = state_q;
      hold_d    = hold_q;
      cnt_d     = cnt_q;
      valid_d   = valid_q;
      pc_d      = pc_q;
      instr_d   = instr_q;
      alu_d     = alu_q;
      flags_d   = flags_q;
      bp_hit_d  = bp_hit_q;
      run_blk_d = run_blk_q && run_req;

      if (cpu_rst_req) begin
         // The request cycle's own edge is the first hold cycle, hence the -1.
         state_d   = StRstHold;
         hold_d    = HOLD_W'(RST_CYCLES - 1);
         cnt_d     = '0;
         valid_d   = 1'b0;
         bp_hit_d  = 1'b0;
         run_blk_d = 1'b0;
      end else begin
         unique case (state_q)
            StRstHold: begin
               if (hold_q == '0) state_d = StIdle;
               else              hold_d  = hold_q - 1'b1;
            end
            StIdle: begin
               if (step_req) begin
                  state_d  = StStep;
                  bp_hit_d = 1'b0;
               end else if (run_ok) begin
                  state_d = StStep;
               end
            end
            StStep: begin
               state_d = StCapture;
               if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
            end
            StCapture: begin
               // SoC outputs already show the post-step state here.
               state_d = StWait;
               valid_d = 1'b1;
               pc_d    = pc_in;
               instr_d = instr_in;
               alu_d   = alu_in;
               flags_d = {regwr_in, memwr_in};
            end
            StWait: begin
               if (trace.ready) begin
                  valid_d = 1'b0;
                  if (bp_match) begin
                     state_d   = StIdle;
                     bp_hit_d  = 1'b1;
                     run_blk_d = 1'b1;
                  end else if (run_ok) begin
                     state_d = StStep;
                  end else begin
                     state_d = StIdle;
                  end
               end
            end
            default: state_d = StRstHold;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= StRstHold;
         hold_q    <= HOLD_W'(RST_CYCLES);
         cnt_q     <= '0;
         cpu_rst_q <= 1'b1;
         cpu_ce_q  <= 1'b0;
         valid_q   <= 1'b0;
         pc_q      <= '0;
         instr_q   <= '0;
         alu_q     <= '0;
         flags_q   <= '0;
         bp_hit_q  <= 1'b0;
         run_blk_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         hold_q    <= hold_d;
         cnt_q     <= cnt_d;
         cpu_rst_q <= (state_d == StRstHold);
         cpu_ce_q  <= (state_d == StStep);
         valid_q   <= valid_d;
         pc_q      <= pc_d;
         instr_q   <= instr_d;
         alu_q     <= alu_d;
         flags_q   <= flags_d;
         bp_hit_q  <= bp_hit_d;
         run_blk_q <= run_blk_d;
      end
   end

   assign cpu_rst     = cpu_rst_q;
   assign cpu_ce      = cpu_ce_q;
   assign cycle_cnt   = cnt_q;
   assign trace.valid = valid_q;
   assign trace.pc    = pc_q;
   assign trace.instr = instr_q;
   assign trace.alu   = alu_q;
   assign trace.flags = flags_q;

endmodule

// File: tb/tb_mips_step_ctrl.sv
// tb_mips_step_ctrl: bench for mips_step_ctrl. A small fake SoC (PC advancing by 4 per enable
// pulse over a random program) feeds two controllers (CNT_W=16 and CNT_W=4) that share stimulus.
// Expected trace records are derived from the step number since the last reset and queued when
// a step is issued; a monitor pops and compares them on each accepted record.
// Breakpoint checks run when MIPS_STEP_BP_EN is defined.
`timescale 1ns/1ps
module tb_mips_step_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, step_req, run_req, cpu_rst_req, ready;
   logic [5:0]  pc_in;
   logic [31:0] instr_in;
   logic [7:0]  alu_in;
   logic        regwr_in, memwr_in;
   logic        cpu_rst0, cpu_ce0, cpu_rst1, cpu_ce1;
   logic [15:0] cnt0;
   logic [3:0]  cnt1;
`ifdef MIPS_STEP_BP_EN
   logic [5:0]  bp_addr;
   logic        bp_en, bp_hit0, bp_hit1;
`endif

   int unsigned errors = 0;
   int unsigned checks = 0;

   mips_step_ctrl_if #(.PC_W(6), .DATA_W(8)) tr0 ();
   mips_step_ctrl_if #(.PC_W(6), .DATA_W(8)) tr1 ();
   assign tr0.ready = ready;
   assign tr1.ready = ready;

   mips_step_ctrl #(.RST_CYCLES(4), .CNT_W(16), .PC_W(6), .DATA_W(8)) dut0 (
      .clk(clk), .rst(rst), .step_req(step_req), .run_req(run_req), .cpu_rst_req(cpu_rst_req),
      .pc_in(pc_in), .instr_in(instr_in), .alu_in(alu_in), .regwr_in(regwr_in),
      .memwr_in(memwr_in),
`ifdef MIPS_STEP_BP_EN
      .bp_addr(bp_addr), .bp_en(bp_en), .bp_hit(bp_hit0),
`endif
      .cpu_rst(cpu_rst0), .cpu_ce(cpu_ce0), .cycle_cnt(cnt0), .trace(tr0)
   );

   mips_step_ctrl #(.RST_CYCLES(4), .CNT_W(4), .PC_W(6), .DATA_W(8)) dut1 (
      .clk(clk), .rst(rst), .step_req(step_req), .run_req(run_req), .cpu_rst_req(cpu_rst_req),
      .pc_in(pc_in), .instr_in(instr_in), .alu_in(alu_in), .regwr_in(regwr_in),
      .memwr_in(memwr_in),
`ifdef MIPS_STEP_BP_EN
      .bp_addr(bp_addr), .bp_en(bp_en), .bp_hit(bp_hit1),
`endif
      .cpu_rst(cpu_rst1), .cpu_ce(cpu_ce1), .cycle_cnt(cnt1), .trace(tr1)
   );

   // Fake SoC: one instruction per enable pulse, PC steps by 4.
   logic [31:0] prog [16];
   logic [5:0]  soc_pc;
   always @(posedge clk) begin
      if (cpu_rst0)     soc_pc <= 6'd0;
      else if (cpu_ce0) soc_pc <= soc_pc + 6'd4;
   end
   assign pc_in    = soc_pc;
   assign instr_in = prog[soc_pc[5:2]];
   assign alu_in   = instr_in[7:0] ^ {2'b00, soc_pc};
   assign regwr_in = instr_in[8];
   assign memwr_in = instr_in[9];

   typedef struct packed {
      logic [5:0]  pc;
      logic [31:0] instr;
      logic [7:0]  alu;
      logic [1:0]  flags;
      logic [15:0] cnt0;
      logic [3:0]  cnt1;
   } rec_t;

   rec_t        exp_q[$];
   int unsigned k_model = 0;
   int unsigned since_ce = 100;
   logic        valid_prev = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Record after the k-th instruction since reset.
   function automatic rec_t exp_rec(input int unsigned k);
      rec_t r;
      r.pc    = 6'(4 * k);
      r.instr = prog[k % 16];
      r.alu   = r.instr[7:0] ^ {2'b00, r.pc};
      r.flags = {r.instr[8], r.instr[9]};
      r.cnt0  = 16'(k);
      r.cnt1  = (k > 15) ? 4'd15 : 4'(k);
      return r;
   endfunction

   // Scoreboard monitor.
   always @(negedge clk) begin
      rec_t e;
      if (!rst || cpu_rst0) begin
         exp_q.delete();
         k_model  = 0;
         since_ce = 100;
      end else begin
         if (since_ce < 100) since_ce++;
         if (cpu_ce0) begin
            chk("ce_gap", 64'(since_ce >= 3), 1);
            chk("ce_while_valid", tr0.valid, 0);
            chk("ce_dut1", cpu_ce1, 1);
            k_model++;
            exp_q.push_back(exp_rec(k_model));
            since_ce = 0;
         end
         if (tr0.valid && !valid_prev) chk("valid_latency", since_ce, 2);
         if (tr0.valid && ready && !cpu_rst_req) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_record", tr0.valid, 0);
            end else begin
               e = exp_q.pop_front();
               chk("rec_pc", tr0.pc, e.pc);
               chk("rec_instr", tr0.instr, e.instr);
               chk("rec_alu", tr0.alu, e.alu);
               chk("rec_flags", tr0.flags, e.flags);
               chk("rec_cnt", cnt0, e.cnt0);
               chk("rec_cnt_sat", cnt1, e.cnt1);
               chk("rec1_pc", tr1.pc, e.pc);
               chk("rec1_valid", tr1.valid, 1);
            end
         end
      end
      valid_prev = tr0.valid;
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic hold_len(output int n, output int bad);
      n = 0;
      bad = 0;
      for (int i = 0; i < 20 && cpu_rst0; i++) begin
         n++;
         if (cpu_ce0 || tr0.valid || cnt0 != 16'd0) bad++;
         cyc();
      end
   endtask

   task automatic wait_valid(input string name);
      int i = 0;
      while (!tr0.valid && i < 10) begin
         cyc();
         i++;
      end
      if (!tr0.valid) chk(name, tr0.valid, 1);
   endtask

   int n, bad, ce_n;

   initial begin
      rst = 1'b0; step_req = 1'b0; run_req = 1'b0; cpu_rst_req = 1'b0; ready = 1'b1;
`ifdef MIPS_STEP_BP_EN
      bp_en = 1'b0; bp_addr = 6'd0;
`endif
      for (int i = 0; i < 16; i++) prog[i] = $urandom;

      // Reset state and hold length.
      cyc(); cyc();
      chk("rst_cpu_rst", cpu_rst0, 1);
      chk("rst_ce", cpu_ce0, 0);
      chk("rst_valid", tr0.valid, 0);
      chk("rst_cnt", cnt0, 0);
      chk("rst_pc", tr0.pc, 0);
      chk("rst_instr", tr0.instr, 0);
      rst = 1'b1;
      cyc();
      hold_len(n, bad);
      chk("rst_hold_len", n, 4);
      chk("rst_hold_quiet", bad, 0);

      // Single step latency.
      step_req = 1'b1; cyc(); step_req = 1'b0;
      chk("step_ce", cpu_ce0, 1);
      cyc();
      chk("step_ce_once", cpu_ce0, 0);
      chk("step_valid_early", tr0.valid, 0);
      cyc();
      chk("step_valid", tr0.valid, 1);
      chk("step_pc", tr0.pc, 4);
      chk("step_cnt", cnt0, 1);
      cyc();
      chk("step_valid_drop", tr0.valid, 0);

      // Back-pressure: payload holds, SoC stalled, requests dropped.
      ready = 1'b0;
      step_req = 1'b1; cyc(); step_req = 1'b0;
      wait_valid("stall_timeout");
      ce_n = 0; bad = 0;
      for (int i = 0; i < 10; i++) begin
         step_req = 1'($urandom_range(0, 1));
         run_req  = 1'($urandom_range(0, 1));
         cyc();
         if (cpu_ce0) ce_n++;
         if (!tr0.valid || tr0.pc != 6'd8 || tr0.instr != prog[2]) bad++;
      end
      step_req = 1'b0; run_req = 1'b0; ready = 1'b1;
      cyc();
      chk("stall_ce", ce_n, 0);
      chk("stall_payload", bad, 0);
      chk("stall_release", tr0.valid, 0);
      cyc();
      chk("step_dropped", cpu_ce0, 0);

      // cpu_rst_req together with step_req while a record is pending.
      ready = 1'b0;
      step_req = 1'b1; cyc(); step_req = 1'b0;
      wait_valid("rreq_timeout");
      cpu_rst_req = 1'b1; step_req = 1'b1; ready = 1'b1;
      cyc();
      cpu_rst_req = 1'b0; step_req = 1'b0;
      chk("rreq_valid", tr0.valid, 0);
      chk("rreq_cnt", cnt0, 0);
      hold_len(n, bad);
      chk("rreq_hold_len", n, 4);
      chk("rreq_hold_quiet", bad, 0);

      // Free run throughput and counter saturation.
      run_req = 1'b1; ce_n = 0;
      for (int i = 0; i < 30; i++) begin
         cyc();
         if (cpu_ce0) ce_n++;
      end
      chk("run_ce_count", ce_n, 10);
      chk("run_cnt", cnt0, 10);
      repeat (30) cyc();
      chk("run_cnt20", cnt0, 20);
      chk("sat_cnt", cnt1, 15);
      run_req = 1'b0;
      repeat (4) cyc();

`ifdef MIPS_STEP_BP_EN
      cpu_rst_req = 1'b1; cyc(); cpu_rst_req = 1'b0;
      hold_len(n, bad);
      bp_addr = 6'd12; bp_en = 1'b1; run_req = 1'b1;
      for (int i = 0; i < 40 && !bp_hit0; i++) cyc();
      chk("bp_hit", bp_hit0, 1);
      chk("bp_steps", k_model, 3);
      ce_n = 0;
      for (int i = 0; i < 10; i++) begin
         cyc();
         if (cpu_ce0) ce_n++;
      end
      chk("bp_halt_ce", ce_n, 0);
      run_req = 1'b0; cyc(); run_req = 1'b1;
      for (int i = 0; i < 5 && !cpu_ce0; i++) cyc();
      chk("bp_resume", cpu_ce0, 1);
      run_req = 1'b0;
      repeat (4) cyc();
      chk("bp_steps2", k_model, 4);
      chk("bp_sticky", bp_hit0, 1);
      bp_en = 1'b0;
      step_req = 1'b1; cyc(); step_req = 1'b0;
      chk("bp_clear", bp_hit0, 0);
      repeat (4) cyc();
`endif

      // Random traffic against the scoreboard.
      for (int i = 0; i < 400; i++) begin
         step_req    = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 9) == 0) run_req = ~run_req;
         ready       = ($urandom_range(0, 2) != 0);
         cpu_rst_req = ($urandom_range(0, 60) == 0);
         cyc();
      end
      step_req = 1'b0; run_req = 1'b0; cpu_rst_req = 1'b0; ready = 1'b1;
      repeat (10) cyc();
      chk("drain", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
